// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci-style sequence engine.
package fib_pkg;

  typedef enum logic [1:0] {
    FIB    = 2'b00,
    LUCAS  = 2'b01,
    CUSTOM = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    HOLD,
    STREAM
  } state_e;

  localparam int unsigned LUCAS_SEED0 = 2;
  localparam int unsigned LUCAS_SEED1 = 1;

endpackage

// File: rtl/fib_step.sv
// One recurrence step: W-bit sum of two terms plus the carry that flags a wrap.
module fib_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         carry_o
);

  logic [W:0] wide;

  always_comb begin
    wide    = {1'b0, a_i} + {1'b0, b_i};
    sum_o   = wide[W-1:0];
    carry_o = wide[W];
  end

endmodule

// File: rtl/fib_seq_engine.sv
// Generalised Fibonacci sequencer: computes term(n) or streams term(0..n) with
// ready/valid handshakes on both sides and a sticky per-request wrap flag.
module fib_seq_engine
  import fib_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned NW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [NW-1:0] req_n,
  input  logic [1:0]    req_mode,
  input  logic [W-1:0]  req_seed0,
  input  logic [W-1:0]  req_seed1,
  input  logic          req_stream,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_term,
  output logic [NW-1:0] out_index,
  output logic          out_last,
  output logic          out_ovf
);

  localparam logic [W-1:0] LUCAS0 = W'(LUCAS_SEED0);
  localparam logic [W-1:0] LUCAS1 = W'(LUCAS_SEED1);

  state_e        state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [NW-1:0] k_q, k_d;
  logic [W-1:0]  a_q, a_d;     // term(k)
  logic [W-1:0]  b_q, b_d;     // term(k+1)
  logic          ovf_q, ovf_d;
  logic          bwrap_q, bwrap_d;
  logic [W-1:0]  sum;
  logic          carry;
  logic          adv;

  fib_step #(.W(W)) u_step (
    .a_i     (a_q),
    .b_i     (b_q),
    .sum_o   (sum),
    .carry_o (carry)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ovf_q   <= 1'b0;
      bwrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ovf_q   <= ovf_d;
      bwrap_q <= bwrap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    k_d       = k_q;
    a_d       = a_q;
    b_d       = b_q;
    ovf_d     = ovf_q;
    bwrap_d   = bwrap_q;
    adv       = 1'b0;
    req_ready = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          n_d     = req_n;
          k_d     = '0;
          ovf_d   = 1'b0;
          bwrap_d = 1'b0;
          case (req_mode)
            LUCAS:   begin a_d = LUCAS0;    b_d = LUCAS1;    end
            CUSTOM:  begin a_d = req_seed0; b_d = req_seed1; end
            default: begin a_d = '0;        b_d = W'(1);     end
          endcase
          state_d = req_stream ? STREAM : CALC;
        end
      end
      CALC: begin
        if (k_q == n_q) state_d = HOLD;
        else            adv     = 1'b1;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      STREAM: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (k_q == n_q) state_d = IDLE;
          else            adv     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The carry belongs to term(k+2); it only reaches out_ovf once k passes it.
    if (adv) begin
      a_d     = b_q;
      b_d     = sum;
      k_d     = k_q + NW'(1);
      ovf_d   = ovf_q | bwrap_q;
      bwrap_d = carry;
    end
  end

  always_comb begin
    out_term  = a_q;
    out_index = k_q;
    out_last  = out_valid && (k_q == n_q);
    out_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_fib_seq_engine.sv
// Self-checking bench for fib_seq_engine (W=16): constant vectors, hand-built
// corner sequences and random requests checked against a prefix-list model.
module tb_fib_seq_engine;

  localparam int unsigned W  = 16;
  localparam int unsigned NW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [NW-1:0] req_n;
  logic [1:0]    req_mode;
  logic [W-1:0]  req_seed0;
  logic [W-1:0]  req_seed1;
  logic          req_stream;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_term;
  logic [NW-1:0] out_index;
  logic          out_last;
  logic          out_ovf;

  int total = 0;
  int bad   = 0;

  longint m_term [0:255];
  bit     m_ovf  [0:255];

  fib_seq_engine #(.W(W), .NW(NW)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_n      (req_n),
    .req_mode   (req_mode),
    .req_seed0  (req_seed0),
    .req_seed1  (req_seed1),
    .req_stream (req_stream),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_term   (out_term),
    .out_index  (out_index),
    .out_last   (out_last),
    .out_ovf    (out_ovf)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Terms as a plain list: seeds, then sum of the previous two reduced mod 2^16;
  // overflow flag is the OR of "sum exceeded 16 bits" over the prefix.
  function automatic void model(input int mode, input longint s0, input longint s1);
    longint s;
    case (mode)
      1:       begin m_term[0] = 2;             m_term[1] = 1;             end
      2:       begin m_term[0] = s0 % 65536;    m_term[1] = s1 % 65536;    end
      default: begin m_term[0] = 0;             m_term[1] = 1;             end
    endcase
    m_ovf[0] = 0;
    m_ovf[1] = 0;
    for (int j = 2; j < 256; j++) begin
      s         = m_term[j-1] + m_term[j-2];
      m_term[j] = s % 65536;
      m_ovf[j]  = m_ovf[j-1] | (s >= 65536);
    end
  endfunction

  function automatic logic pick_ready(input int rmode, input int cyc);
    case (rmode)
      0:       return 1'b1;
      1:       return (cyc % 2) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Issue one request, check every presented output, drain it; return last output.
  task automatic run_req(input int n, input int mode, input int s0, input int s1,
                         input int stream, input int rmode, input string tag,
                         output longint last_term, output longint last_ovf);
    int  exp_k;
    int  edges;
    int  cyc;
    bit  done;
    logic rdy;
    last_term = -1;
    last_ovf  = -1;
    @(negedge clock);
    chk({tag, " req_ready"}, req_ready, 1);
    req_valid  = 1'b1;
    req_n      = NW'(n);
    req_mode   = 2'(mode);
    req_seed0  = W'(s0);
    req_seed1  = W'(s1);
    req_stream = 1'(stream);
    out_ready  = pick_ready(rmode, 0);
    @(posedge clock); #1;
    req_valid  = 1'b0;
    req_n      = NW'($urandom);
    req_mode   = 2'($urandom);
    req_seed0  = W'($urandom);
    req_seed1  = W'($urandom);
    req_stream = 1'($urandom);
    model(mode, s0, s1);
    exp_k = stream ? 0 : n;
    if (stream == 0) begin
      edges = 0;
      while (!out_valid && edges < n + 5) begin
        @(posedge clock); #1;
        edges++;
      end
      chk({tag, " latency"}, edges, n + 1);
    end
    done = 0;
    cyc  = 0;
    while (!done && cyc < 1000) begin
      chk({tag, " out_valid"}, out_valid, 1);
      chk({tag, " out_index"}, out_index, exp_k);
      chk({tag, " out_term"},  out_term,  m_term[exp_k]);
      chk({tag, " out_last"},  out_last,  exp_k == n);
      chk({tag, " out_ovf"},   out_ovf,   m_ovf[exp_k]);
      last_term = out_term;
      last_ovf  = out_ovf;
      rdy = (cyc == 0 && rmode != 2) ? out_ready : pick_ready(rmode, cyc);
      out_ready = rdy;
      @(posedge clock); #1;
      if (rdy) begin
        if (exp_k == n) done = 1;
        else            exp_k++;
      end
      cyc++;
    end
    chk({tag, " drained"}, done, 1);
    chk({tag, " idle valid"}, out_valid, 0);
    chk({tag, " idle ready"}, req_ready, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req_ready"}, req_ready, 1);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_term"},  out_term,  0);
    chk({tag, " out_index"}, out_index, 0);
    chk({tag, " out_last"},  out_last,  0);
    chk({tag, " out_ovf"},   out_ovf,   0);
  endtask

  typedef struct {
    int     n;
    int     mode;
    int     s0;
    int     s1;
    longint exp_term;
    longint exp_ovf;
  } vec_t;

  initial begin
    vec_t   vecs [10];
    longint t;
    longint o;
    int     nvalid;
    int     nready;
    int     edges;

    vecs[0] = '{10, 0, 0, 0, 55,    0};
    vecs[1] = '{5,  1, 0, 0, 11,    0};
    vecs[2] = '{3,  2, 3, 4, 11,    0};
    vecs[3] = '{0,  0, 0, 0, 0,     0};
    vecs[4] = '{1,  0, 0, 0, 1,     0};
    vecs[5] = '{24, 0, 0, 0, 46368, 0};
    vecs[6] = '{25, 0, 0, 0, 9489,  1};
    vecs[7] = '{6,  3, 9, 9, 8,     0};
    vecs[8] = '{0,  2, 7, 9, 7,     0};
    vecs[9] = '{1,  1, 0, 0, 1,     0};

    reset = 1'b1; req_valid = 1'b0; req_n = '0; req_mode = '0;
    req_seed0 = '0; req_seed1 = '0; req_stream = 1'b0; out_ready = 1'b1;
    #12;
    chk_reset_outputs("por");
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].n, vecs[i].mode, vecs[i].s0, vecs[i].s1, 0, 0,
              $sformatf("vec%0d", i), t, o);
      chk($sformatf("vec%0d term", i), t, vecs[i].exp_term);
      chk($sformatf("vec%0d ovf", i),  o, vecs[i].exp_ovf);
    end

    run_req(4, 0, 0, 0, 1, 1, "stream4", t, o);
    chk("stream4 final", t, 3);
    run_req(0, 0, 0, 0, 1, 0, "stream0", t, o);
    chk("stream0 final", t, 0);
    run_req(30, 0, 0, 0, 1, 2, "stream30", t, o);
    run_req(5, 0, 0, 0, 0, 1, "holdstall", t, o);

    // Reset mid-CALC at k=3 of n=10
    @(negedge clock);
    req_valid = 1'b1; req_n = 8'd10; req_mode = 2'b00; req_stream = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("midcalc index", out_index, 3);
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst calc");
    #2 reset = 1'b0;
    run_req(6, 0, 0, 0, 0, 0, "after rst", t, o);
    chk("after rst term", t, 8);

    // Reset mid-STREAM
    @(negedge clock);
    req_valid = 1'b1; req_n = 8'd10; req_mode = 2'b01; req_stream = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("midstream valid", out_valid, 1);
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst stream");
    #2 reset = 1'b0;

    // req_valid held high while busy: one request served, next only after IDLE
    @(negedge clock);
    req_valid = 1'b1; req_n = 8'd2; req_mode = 2'b00; req_stream = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    nvalid = 0;
    nready = 0;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clock); #1;
      nvalid += int'(out_valid);
      nready += int'(req_ready);
    end
    chk("busy valid count", nvalid, 1);
    chk("busy ready count", nready, 1);
    req_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 6) begin
      @(posedge clock); #1;
      edges++;
    end
    chk("requeue edges", edges, 1);
    chk("requeue term", out_term, 1);
    @(posedge clock); #1;
    chk("requeue idle", req_ready, 1);

    for (int r = 0; r < 30; r++) begin
      run_req(int'($urandom_range(0, 40)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 1)), 2, $sformatf("rnd%0d", r), t, o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
